// File: rtl/pwm_reg_pkg.sv
// Shared definitions for the PWM register block and its bus initiator:
// register addresses, CONTROL bit positions, sequencer FSM states and the
// step -> (address, data source) table used by the configuration sequencer.
package pwm_reg_pkg;

  localparam logic [15:0] ADDR_PERIOD    = 16'h0000;
  localparam logic [15:0] ADDR_CCR_ON    = 16'h0004;
  localparam logic [15:0] ADDR_CCR       = 16'h0008;
  localparam logic [15:0] ADDR_CONTROL   = 16'h000C;
  localparam logic [15:0] ADDR_PRESCALER = 16'h000E;
  localparam logic [15:0] ADDR_DEADTIME  = 16'h0010;

  localparam int EN_BIT   = 0;
  localparam int MODE_BIT = 1;

  // Steps 0..6 are the write program, 7..12 the optional readback program.
  localparam logic [3:0] LAST_WRITE_STEP = 4'd6;
  localparam logic [3:0] LAST_READ_STEP  = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_GAP_WAIT = 3'd3,
    ST_READ     = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // Which latched configuration value a bus access carries (or expects).
  typedef enum logic [2:0] {
    SRC_ZERO      = 3'd0,
    SRC_PERIOD    = 3'd1,
    SRC_CCR_ON    = 3'd2,
    SRC_CCR       = 3'd3,
    SRC_PRESCALER = 3'd4,
    SRC_DEADTIME  = 3'd5,
    SRC_CONTROL   = 3'd6
  } src_t;

  typedef struct packed {
    logic [15:0] addr;
    src_t        src;
  } step_map_t;

  // Core is disabled first so it never runs on a half-written timing set.
  function automatic step_map_t step_map(input logic [3:0] step);
    step_map_t m;
    m.addr = ADDR_PERIOD;
    m.src  = SRC_ZERO;
    case (step)
      4'd0:    begin m.addr = ADDR_CONTROL;   m.src = SRC_ZERO;      end
      4'd1:    begin m.addr = ADDR_PERIOD;    m.src = SRC_PERIOD;    end
      4'd2:    begin m.addr = ADDR_CCR_ON;    m.src = SRC_CCR_ON;    end
      4'd3:    begin m.addr = ADDR_CCR;       m.src = SRC_CCR;       end
      4'd4:    begin m.addr = ADDR_PRESCALER; m.src = SRC_PRESCALER; end
      4'd5:    begin m.addr = ADDR_DEADTIME;  m.src = SRC_DEADTIME;  end
      4'd6:    begin m.addr = ADDR_CONTROL;   m.src = SRC_CONTROL;   end
      4'd7:    begin m.addr = ADDR_PERIOD;    m.src = SRC_PERIOD;    end
      4'd8:    begin m.addr = ADDR_CCR_ON;    m.src = SRC_CCR_ON;    end
      4'd9:    begin m.addr = ADDR_CCR;       m.src = SRC_CCR;       end
      4'd10:   begin m.addr = ADDR_PRESCALER; m.src = SRC_PRESCALER; end
      4'd11:   begin m.addr = ADDR_DEADTIME;  m.src = SRC_DEADTIME;  end
      4'd12:   begin m.addr = ADDR_CONTROL;   m.src = SRC_CONTROL;   end
      default: begin m.addr = ADDR_PERIOD;    m.src = SRC_ZERO;      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer: on start, latches a full PWM configuration,
// range-checks it, disables the core, writes every timing register and
// re-enables the core through the memory-mapped register bus.
// Optional build macro PWM_CFG_READBACK_EN adds a readback/compare pass
// after the writes; a mismatch is reported as error with done.
module pwm_cfg_sequencer
  import pwm_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_ccr_on,
  input  logic [WIDTH-1:0] cfg_ccr,
  input  logic             cfg_en,
  input  logic             cfg_mode,
  input  logic [15:0]      cfg_prescaler,
  input  logic [15:0]      cfg_deadtime,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             wr_en,
  output logic             rd_en,
  output logic [15:0]      addr,
  output logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] rd_data
);

`ifdef PWM_CFG_READBACK_EN
  localparam logic [3:0] LAST_STEP = LAST_READ_STEP;
`else
  localparam logic [3:0] LAST_STEP = LAST_WRITE_STEP;
`endif

  // Gap counter preload; counts GAP idle cycles down to zero.
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] ccr_on_q, ccr_on_d;
  logic [WIDTH-1:0] ccr_q, ccr_d;
  logic [15:0]      presc_q, presc_d;
  logic [15:0]      dead_q, dead_d;
  logic             en_q, en_d;
  logic             mode_q, mode_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [15:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic [3:0]       acc_step;
  step_map_t        acc_map;
  logic [WIDTH-1:0] acc_val;
  logic             readback_err;

  function automatic logic [WIDTH-1:0] reg_value(
    input src_t             s,
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] co,
    input logic [WIDTH-1:0] c,
    input logic [15:0]      pr,
    input logic [15:0]      dt,
    input logic             e,
    input logic             m
  );
    logic [WIDTH-1:0] v;
    v = '0;
    case (s)
      SRC_PERIOD:    v = p;
      SRC_CCR_ON:    v = co;
      SRC_CCR:       v = c;
      SRC_PRESCALER: v[15:0] = pr;
      SRC_DEADTIME:  v[15:0] = dt;
      SRC_CONTROL:   begin v[EN_BIT] = e; v[MODE_BIT] = m; end
      default:       v = '0;
    endcase
    return v;
  endfunction

  // Next bus access: the step that the sequencer would issue next.
  always_comb begin
    acc_step = (state_q == ST_CHECK) ? 4'd0 : step_q + 4'd1;
    acc_map  = step_map(acc_step);
    acc_val  = reg_value(acc_map.src, period_q, ccr_on_q, ccr_q,
                         presc_q, dead_q, en_q, mode_q);
  end

`ifdef PWM_CFG_READBACK_EN
  step_map_t        cur_map;
  logic [WIDTH-1:0] cur_val;
  logic             rd_bad;
  logic             mismatch_q, mismatch_d;

  // Compare the slave's read data in the same cycle as the read strobe.
  always_comb begin
    cur_map      = step_map(step_q);
    cur_val      = reg_value(cur_map.src, period_q, ccr_on_q, ccr_q,
                             presc_q, dead_q, en_q, mode_q);
    rd_bad       = (state_q == ST_READ) && (rd_data != cur_val);
    readback_err = mismatch_q | rd_bad;
  end

  // Sticky mismatch flag, cleared when a new request is accepted.
  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == ST_IDLE && start) begin
      mismatch_d = 1'b0;
    end else if (rd_bad) begin
      mismatch_d = 1'b1;
    end
  end

  // Mismatch flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign readback_err   = 1'b0;
`endif

  // Sequencer FSM; all bus outputs are computed here one cycle ahead.
  always_comb begin
    logic go_next;
    go_next   = 1'b0;
    state_d   = state_q;
    step_d    = step_q;
    gap_d     = gap_q;
    period_d  = period_q;
    ccr_on_d  = ccr_on_q;
    ccr_d     = ccr_q;
    presc_d   = presc_q;
    dead_d    = dead_q;
    en_d      = en_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = '0;
    wr_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          period_d = cfg_period;
          ccr_on_d = cfg_ccr_on;
          ccr_d    = cfg_ccr;
          presc_d  = cfg_prescaler;
          dead_d   = cfg_deadtime;
          en_d     = cfg_en;
          mode_d   = cfg_mode;
          busy_d   = 1'b1;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ccr_q > period_q || ccr_on_q > period_q) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          go_next = 1'b1;
        end
      end
      ST_WRITE, ST_READ: begin
        if (step_q == LAST_STEP) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          error_d = readback_err;
          busy_d  = 1'b0;
        end else if (GAP == 0) begin
          go_next = 1'b1;
        end else begin
          state_d = ST_GAP_WAIT;
          gap_d   = GAP_LOAD;
        end
      end
      ST_GAP_WAIT: begin
        if (gap_q == 4'd0) begin
          go_next = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (go_next) begin
      step_d = acc_step;
      addr_d = acc_map.addr;
      if (acc_step <= LAST_WRITE_STEP) begin
        state_d   = ST_WRITE;
        wr_en_d   = 1'b1;
        wr_data_d = acc_val;
      end else begin
        state_d = ST_READ;
        rd_en_d = 1'b1;
      end
    end
  end

  // State, latched configuration and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      gap_q     <= '0;
      period_q  <= '0;
      ccr_on_q  <= '0;
      ccr_q     <= '0;
      presc_q   <= '0;
      dead_q    <= '0;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      gap_q     <= gap_d;
      period_q  <= period_d;
      ccr_on_q  <= ccr_on_d;
      ccr_q     <= ccr_d;
      presc_q   <= presc_d;
      dead_q    <= dead_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: two instances (GAP=0 and GAP=2) each with a
// register-slave model; directed table, reset-abort sequence and random runs
// are checked against a schedule model built from the register program.
module tb_pwm_cfg_sequencer;

`ifdef PWM_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct {
    logic [31:0] period;
    logic [31:0] ccr_on;
    logic [31:0] ccr;
    logic [15:0] presc;
    logic [15:0] dead;
    logic        en;
    logic        mode;
  } cfg_t;

  typedef struct {
    int   dut;
    cfg_t cfg;
    bit   corrupt;
    int   extra_rel;
    int   exp_done;
    int   exp_err;
  } vec_t;

  typedef struct {
    int          dut;
    int          cyc;
    bit          rd;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic [31:0] cfg_period, cfg_ccr_on, cfg_ccr;
  logic        cfg_en, cfg_mode;
  logic [15:0] cfg_prescaler, cfg_deadtime;
  logic        busy_o [2];
  logic        done_o [2];
  logic        error_o [2];
  logic        wr_en_o [2];
  logic        rd_en_o [2];
  logic [15:0] addr_o [2];
  logic [31:0] wr_data_o [2];
  logic [31:0] rd_data_i [2];
  logic [31:0] mem [2][32];
  bit          corrupt [2];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;
  acc_t log_q[$];
  acc_t exp_q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_cfg_sequencer #(.WIDTH(32), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .cfg_period(cfg_period), .cfg_ccr_on(cfg_ccr_on), .cfg_ccr(cfg_ccr),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_prescaler(cfg_prescaler), .cfg_deadtime(cfg_deadtime),
    .busy(busy_o[0]), .done(done_o[0]), .error(error_o[0]),
    .wr_en(wr_en_o[0]), .rd_en(rd_en_o[0]), .addr(addr_o[0]),
    .wr_data(wr_data_o[0]), .rd_data(rd_data_i[0])
  );

  pwm_cfg_sequencer #(.WIDTH(32), .GAP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .cfg_period(cfg_period), .cfg_ccr_on(cfg_ccr_on), .cfg_ccr(cfg_ccr),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_prescaler(cfg_prescaler), .cfg_deadtime(cfg_deadtime),
    .busy(busy_o[1]), .done(done_o[1]), .error(error_o[1]),
    .wr_en(wr_en_o[1]), .rd_en(rd_en_o[1]), .addr(addr_o[1]),
    .wr_data(wr_data_o[1]), .rd_data(rd_data_i[1])
  );

  // Register slave models: store on write, combinational read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en_o[i] === 1'b1) mem[i][addr_o[i][5:1]] <= wr_data_o[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_data_i[i] = mem[i][addr_o[i][5:1]];
      if (corrupt[i] && addr_o[i] == 16'h0008) rd_data_i[i] = 32'd499;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor and per-cycle bus rules.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        acc_t a;
        bit   bad;
        if (wr_en_o[i] || rd_en_o[i]) begin
          a.dut  = i;
          a.cyc  = cyc;
          a.rd   = rd_en_o[i];
          a.addr = addr_o[i];
          a.data = wr_data_o[i];
          log_q.push_back(a);
        end
        bad = (wr_en_o[i] && rd_en_o[i]) ||
              (!wr_en_o[i] && !rd_en_o[i] && (addr_o[i] != 16'h0 || wr_data_o[i] != 32'h0)) ||
              (error_o[i] && !done_o[i]) || (done_o[i] && busy_o[i]);
        if (bad) check($sformatf("bus_rules_dut%0d", i), 1, 0);
      end
    end
  end

  function automatic cfg_t mk(input logic [31:0] p, input logic [31:0] co, input logic [31:0] c,
                              input logic [15:0] pr, input logic [15:0] dt,
                              input logic e, input logic m);
    cfg_t r;
    r.period = p; r.ccr_on = co; r.ccr = c; r.presc = pr; r.dead = dt; r.en = e; r.mode = m;
    return r;
  endfunction

  // Expected schedule: register program laid out at one access per GAP+1 cycles.
  function automatic void model(input cfg_t c, input int gap, input bit corr,
                                output int done_rel, output bit err);
    logic [15:0] wa [7];
    logic [31:0] wd [7];
    logic [15:0] ra [6];
    acc_t        a;
    int          t;
    exp_q.delete();
    err = 1'b0;
    if (c.ccr > c.period || c.ccr_on > c.period) begin
      done_rel = 2;
      err = 1'b1;
      return;
    end
    wa = '{16'h0C, 16'h00, 16'h04, 16'h08, 16'h0E, 16'h10, 16'h0C};
    wd = '{32'd0, c.period, c.ccr_on, c.ccr, {16'd0, c.presc}, {16'd0, c.dead},
           {30'd0, c.mode, c.en}};
    ra = '{16'h00, 16'h04, 16'h08, 16'h0E, 16'h10, 16'h0C};
    t = 2;
    for (int k = 0; k < 7; k++) begin
      a.dut = 0; a.cyc = t; a.rd = 1'b0; a.addr = wa[k]; a.data = wd[k];
      exp_q.push_back(a);
      t += gap + 1;
    end
    if (READBACK) begin
      for (int k = 0; k < 6; k++) begin
        a.dut = 0; a.cyc = t; a.rd = 1'b1; a.addr = ra[k]; a.data = 32'd0;
        exp_q.push_back(a);
        t += gap + 1;
      end
      err = corr && (c.ccr != 32'd499);
    end
    done_rel = t - gap;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_period = c.period; cfg_ccr_on = c.ccr_on; cfg_ccr = c.ccr;
    cfg_prescaler = c.presc; cfg_deadtime = c.dead; cfg_en = c.en; cfg_mode = c.mode;
  endtask

  task automatic drive_garbage();
    cfg_period = $urandom; cfg_ccr_on = $urandom; cfg_ccr = $urandom;
    cfg_prescaler = 16'($urandom); cfg_deadtime = 16'($urandom);
    cfg_en = 1'($urandom); cfg_mode = 1'($urandom);
  endtask

  // One request: start pulse, optional ignored re-start, wait for done, compare.
  task automatic run(input int d, input cfg_t c, input bit corr, input int extra_rel,
                     input int tbl_done, input int tbl_err);
    int done_rel, c0, got_rel, n, other;
    bit err_exp, seen, got_err;
    model(c, (d == 0) ? 0 : 2, corr, done_rel, err_exp);
    corrupt[d] = corr;
    @(negedge clk);
    log_q.delete();
    drive_cfg(c);
    start[d] = 1'b1;
    c0 = cyc;
    seen = 1'b0; got_rel = -1; got_err = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      start[d] = (k == extra_rel);
      drive_garbage();
      if (done_o[d]) begin
        seen = 1'b1;
        got_rel = cyc - c0;
        got_err = error_o[d];
      end
    end
    start[d] = 1'b0;
    check("done_seen", seen, 1);
    check("done_cycle", got_rel, done_rel);
    check("error", got_err, err_exp);
    if (tbl_done >= 0) check("tbl_done_cycle", got_rel, tbl_done);
    if (tbl_err >= 0) check("tbl_error", got_err, tbl_err);
    n = 0; other = 0;
    foreach (log_q[j]) begin
      if (log_q[j].dut != d) begin
        other++;
      end else begin
        if (n < exp_q.size()) begin
          check($sformatf("acc%0d_cycle", n), log_q[j].cyc - c0, exp_q[n].cyc);
          check($sformatf("acc%0d_rd", n), log_q[j].rd, exp_q[n].rd);
          check($sformatf("acc%0d_addr", n), log_q[j].addr, exp_q[n].addr);
          if (!exp_q[n].rd) check($sformatf("acc%0d_data", n), log_q[j].data, exp_q[n].data);
        end
        n++;
      end
    end
    check("acc_count", n, exp_q.size());
    check("other_dut_quiet", other, 0);
    if (exp_q.size() != 0) begin
      check("slave_period", mem[d][0], c.period);
      check("slave_ccr_on", mem[d][2], c.ccr_on);
      check("slave_ccr", mem[d][4], c.ccr);
      check("slave_presc", mem[d][7], {16'd0, c.presc});
      check("slave_dead", mem[d][8], {16'd0, c.dead});
      check("slave_control", mem[d][6], {30'd0, c.mode, c.en});
    end
    $display("run dut_gap=%0d period=%0d ccr_on=%0d ccr=%0d corrupt=%0d -> done@%0d err=%0d accesses=%0d",
             (d == 0) ? 0 : 2, c.period, c.ccr_on, c.ccr, corr, got_rel, got_err, n);
  endtask

  initial begin
    int   done_cnt, c0;
    cfg_t rc;
    int   d;
    int   done0, done2;
    done0 = READBACK ? 15 : 9;
    done2 = READBACK ? 39 : 21;

    tbl[0] = '{0, mk(1000, 100, 500, 4, 3, 1, 0), 0, -1, done0, 0};
    tbl[1] = '{0, mk(1000, 100, 1200, 4, 3, 1, 0), 0, -1, 2, 1};
    tbl[2] = '{1, mk(1000, 100, 500, 4, 3, 1, 0), 0, 5, done2, 0};
    tbl[3] = '{0, mk(1000, 100, 500, 4, 3, 1, 0), 1, -1, done0, int'(READBACK)};
    tbl[4] = '{0, mk(1000, 1001, 500, 4, 3, 1, 0), 0, -1, 2, 1};
    tbl[5] = '{0, mk(1000, 1000, 1000, 0, 0, 0, 1), 0, -1, done0, 0};
    tbl[6] = '{0, mk(32'hFFFF_FFFF, 7, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 1, 1), 1, -1, done0, int'(READBACK)};
    tbl[7] = '{1, mk(10, 11, 5, 1, 1, 1, 0), 0, -1, 2, 1};
    tbl[8] = '{0, mk(1000, 100, 499, 4, 3, 1, 0), 1, -1, done0, 0};

    rst_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    corrupt[0] = 1'b0; corrupt[1] = 1'b0;
    drive_cfg(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", busy_o[i], 0);
      check("reset_done", done_o[i], 0);
      check("reset_error", error_o[i], 0);
      check("reset_wr_en", wr_en_o[i], 0);
      check("reset_rd_en", rd_en_o[i], 0);
      check("reset_addr", addr_o[i], 0);
      check("reset_wr_data", wr_data_o[i], 0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run(tbl[v].dut, tbl[v].cfg, tbl[v].corrupt, tbl[v].extra_rel, tbl[v].exp_done, tbl[v].exp_err);
    end

    // Reset during the CCR write: strobes drop, no done, next run is clean.
    corrupt[0] = 1'b0;
    @(negedge clk);
    drive_cfg(tbl[0].cfg);
    start[0] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_at_step3_wr_en", wr_en_o[0], 1);
    check("abort_at_step3_addr", addr_o[0], 16'h0008);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_wr_en", wr_en_o[0], 0);
    check("abort_rst_rd_en", rd_en_o[0], 0);
    check("abort_rst_busy", busy_o[0], 0);
    check("abort_rst_done", done_o[0], 0);
    check("abort_rst_addr", addr_o[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o[0] || done_o[1]) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_access", log_q.size(), 0);
    $display("reset abort: started at cycle %0d, released, %0d done pulses after", c0, done_cnt);
    run(tbl[0].dut, tbl[0].cfg, 1'b0, -1, tbl[0].exp_done, tbl[0].exp_err);

    // Random requests on either instance, mostly valid, some out of range.
    for (int r = 0; r < 30; r++) begin
      d = $urandom_range(0, 1);
      rc.period = $urandom_range(1, 32'hFFFF_F000);
      rc.ccr    = $urandom_range(0, rc.period);
      rc.ccr_on = $urandom_range(0, rc.period);
      if ($urandom_range(0, 4) == 0) rc.ccr = rc.period + $urandom_range(1, 100);
      if ($urandom_range(0, 4) == 0) rc.ccr_on = rc.period + $urandom_range(1, 100);
      rc.presc = 16'($urandom);
      rc.dead  = 16'($urandom);
      rc.en    = 1'($urandom);
      rc.mode  = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(d, rc, 1'($urandom), -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
